rx_frame_manager: RTL
=====================

Name: rx_frame_manager

Overview:
Frame-level controller sitting directly behind rx_receiver on the receive clock. It classifies each completed frame (CRC, destination match), queues accepted payloads in a small FIFO for the consumer, and requests an ACK/NAK transmission from the shared transmit path via a req/grant handshake. It also keeps saturating per-category frame statistics for LEDR/HEX display.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
CNT_W, 8, width of each statistics counter
LVL_W, 3, width of fifo_level; must equal clog2(DEPTH+1)

Ports:
clk  in  1  receive clock; same clock that drives rx_receiver
rst_n  in  1  asynchronous active-low reset
my_id  in  2  local node ID (SW[9:8])
frm_valid  in  1  one-cycle pulse per completed frame from rx_receiver
frm_crc_err  in  1  CRC error flag; qualified by frm_valid
frm_dest  in  2  destination ID; qualified by frm_valid
frm_src  in  2  source ID; qualified by frm_valid
frm_payload  in  128  payload; qualified by frm_valid
out_valid  out  1  FIFO head available
out_ready  in  1  consumer accepts the head
out_src  out  2  source ID of the head entry
out_payload  out  128  payload of the head entry
ack_req  out  1  request to transmit an ACK/NAK
ack_grant  in  1  transmit path accepts the request
ack_dest  out  2  node the ACK/NAK is addressed to (held frm_src)
ack_is_nak  out  1  1 = NAK (overflow), 0 = ACK
cnt_clr  in  1  synchronous clear of all counters
cnt_good  out  CNT_W  frames accepted into the FIFO
cnt_crc  out  CNT_W  frames dropped for CRC error
cnt_drop  out  CNT_W  frames dropped for address mismatch
cnt_ovf  out  CNT_W  frames lost to a full FIFO or a busy controller
fifo_level  out  LVL_W  current FIFO occupancy

Behaviour:
- Reset: state IDLE, FIFO empty. All outputs are 0: out_valid, ack_req, ack_is_nak, ack_dest, all counters and fifo_level. out_payload and out_src read as 0 while empty.
- FSM states: IDLE, EVAL, ACK_WAIT.
- IDLE: when frm_valid = 1 at edge t, latch crc/dest/src/payload into holding registers and go to EVAL.
- EVAL occupies exactly one cycle (t+1) and applies these rules in priority order:
  1. crc_err: cnt_crc+1, no ACK, go to IDLE.
  2. dest != my_id: cnt_drop+1, go to IDLE.
  3. FIFO full (after any pop in the same cycle): cnt_ovf+1, ack_is_nak=1, go to ACK_WAIT.
  4. Otherwise: push {src,payload}, cnt_good+1, ack_is_nak=0, go to ACK_WAIT.
- ack_req, ack_dest and ack_is_nak are registered and become valid at t+2. They stay stable until ack_grant is sampled high. ack_req drops on the cycle after the grant, and the FSM returns to IDLE.
- ack_grant is ignored while ack_req = 0.
- frm_valid seen in EVAL or ACK_WAIT: the frame is discarded and cnt_ovf+1. The holding registers are not overwritten.
- FIFO behaviour:
  - First-word fall-through: out_valid = not empty, with the head presented combinationally from storage.
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle are legal, and the level is unchanged.
  - A pop while empty is ignored.
  - Pointers wrap modulo DEPTH.
  - An accepted frame is visible on out_valid at t+2.
- Counters saturate at all-ones. cnt_clr has priority over an increment in the same cycle. cnt_clr does not affect the FIFO or the FSM.
- Reset asserted mid-operation aborts any pending ACK and empties the FIFO immediately (asynchronous).
- frm_* inputs are sampled only on frm_valid. frm_valid is a single-cycle pulse in the clk domain.

Optional Feature:
Macro RX_BCAST_EN.
- Defined: frm_dest = 2'b11 is accepted regardless of my_id. A broadcast frame is pushed, or counted in cnt_ovf if the FIFO is full, but never raises ack_req; the FSM goes EVAL -> IDLE. No cnt_drop increment for broadcasts.
- Undefined: 2'b11 is an ordinary ID, matched only when my_id = 2'b11.

Test Plan:
- my_id=1, frame dest=1 src=2 payload=128'h0123...CDEF, crc ok, out_ready=0 -> out_valid=1 at t+2 with out_src=2 and matching payload. ack_req=1 with ack_dest=2 and ack_is_nak=0; it holds for 5 cycles with grant low, then drops 1 cycle after grant. cnt_good=1.
- Frames with crc_err=1, then dest=3 with my_id=1 -> cnt_crc=1, cnt_drop=1, ack_req never asserted, fifo_level=0.
- With out_ready=0, send 5 good frames granting each ACK -> fifo_level=4. 5th frame gives ack_is_nak=1 and cnt_ovf=1. Draining 4 pops returns the payloads in order, and out_valid=0 afterwards.
- frm_valid pulsed while in ACK_WAIT -> cnt_ovf+1. Original ack_dest is unchanged and no extra FIFO entry is added.
- Force cnt_drop to 255 via 256 mismatches -> stays 255. cnt_clr with a simultaneous mismatch -> 0.
- RX_BCAST_EN defined, my_id=0, dest=3 -> entry pushed, ack_req stays 0. Undefined -> cnt_drop+1. Reset pulsed during ACK_WAIT with FIFO level 2 -> all outputs 0 immediately.

Source files
------------

// File: rtl/rx_frame_manager.sv
`default_nettype none
// rx_frame_manager: classifies received frames, queues accepted payloads in a FWFT FIFO,
// requests ACK/NAK transmission and keeps saturating statistics. Optional macro: RX_BCAST_EN.
module rx_frame_manager #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8,
  parameter int LVL_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         my_id,
  input  logic               frm_valid,
  input  logic               frm_crc_err,
  input  logic [1:0]         frm_dest,
  input  logic [1:0]         frm_src,
  input  logic [127:0]       frm_payload,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_src,
  output logic [127:0]       out_payload,
  output logic               ack_req,
  input  logic               ack_grant,
  output logic [1:0]         ack_dest,
  output logic               ack_is_nak,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   cnt_good,
  output logic [CNT_W-1:0]   cnt_crc,
  output logic [CNT_W-1:0]   cnt_drop,
  output logic [CNT_W-1:0]   cnt_ovf,
  output logic [LVL_W-1:0]   fifo_level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EVAL     = 2'd1,
    ACK_WAIT = 2'd2
  } state_t;

  state_t             state;
  logic               h_crc;
  logic [1:0]         h_dest;
  logic [1:0]         h_src;
  logic [127:0]       h_payload;

  logic [129:0]       mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]   level;

  logic               pop;
  logic               push;
  logic               full_eff;
  logic               bcast;
  logic               dest_ok;
  logic               in_eval;
  logic               eval_ovf;
  logic               late_ovf;
  logic [1:0]         ovf_inc;

`ifdef RX_BCAST_EN
  assign bcast = (h_dest == 2'b11);
`else
  assign bcast = 1'b0;
`endif

  assign out_valid   = (level != '0);
  assign pop         = out_valid && out_ready;
  // Fullness is judged after a same-cycle pop so a draining FIFO never NAKs.
  assign full_eff    = (level == LVL_W'(DEPTH)) && !pop;
  assign dest_ok     = (h_dest == my_id) || bcast;
  assign in_eval     = (state == EVAL);
  assign push        = in_eval && !h_crc && dest_ok && !full_eff;
  assign eval_ovf    = in_eval && !h_crc && dest_ok && full_eff;
  assign late_ovf    = frm_valid && (state != IDLE);
  assign ovf_inc     = {1'b0, eval_ovf} + {1'b0, late_ovf};
  assign out_src     = out_valid ? mem[rd_ptr][129:128] : 2'b00;
  assign out_payload = out_valid ? mem[rd_ptr][127:0]   : 128'd0;
  assign fifo_level  = level;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, c} + {{(CNT_W-1){1'b0}}, inc};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      h_crc      <= 1'b0;
      h_dest     <= 2'b00;
      h_src      <= 2'b00;
      h_payload  <= 128'd0;
      ack_req    <= 1'b0;
      ack_dest   <= 2'b00;
      ack_is_nak <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (frm_valid) begin
            h_crc     <= frm_crc_err;
            h_dest    <= frm_dest;
            h_src     <= frm_src;
            h_payload <= frm_payload;
            state     <= EVAL;
          end
        end
        EVAL: begin
          if (h_crc || !dest_ok || bcast) begin
            state <= IDLE;
          end else begin
            ack_req    <= 1'b1;
            ack_dest   <= h_src;
            ack_is_nak <= full_eff;
            state      <= ACK_WAIT;
          end
        end
        ACK_WAIT: begin
          if (ack_grant) begin
            ack_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {h_src, h_payload};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_good <= '0;
      cnt_crc  <= '0;
      cnt_drop <= '0;
      cnt_ovf  <= '0;
    end else if (cnt_clr) begin
      cnt_good <= '0;
      cnt_crc  <= '0;
      cnt_drop <= '0;
      cnt_ovf  <= '0;
    end else begin
      cnt_good <= sat_add(cnt_good, {1'b0, push});
      cnt_crc  <= sat_add(cnt_crc,  {1'b0, in_eval && h_crc});
      cnt_drop <= sat_add(cnt_drop, {1'b0, in_eval && !h_crc && !dest_ok});
      cnt_ovf  <= sat_add(cnt_ovf,  ovf_inc);
    end
  end

endmodule
`default_nettype wire
